// File: rtl/tl_pkg.sv
// Shared definitions for the two-road traffic light sequencer:
// phase encodings, lamp codes and the lamp decode helpers.
package tl_pkg;

  typedef enum logic [2:0] {
    S_MAIN_G = 3'd0,
    S_MAIN_Y = 3'd1,
    S_ALL_R1 = 3'd2,
    S_SIDE_G = 3'd3,
    S_SIDE_Y = 3'd4,
    S_ALL_R2 = 3'd5
  } tl_state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Unlisted codes (including the illegal 6/7) fall to red.
  function automatic logic [2:0] main_lamp(input logic [2:0] s);
    case (s)
      S_MAIN_G: main_lamp = LAMP_G;
      S_MAIN_Y: main_lamp = LAMP_Y;
      default:  main_lamp = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input logic [2:0] s);
    case (s)
      S_SIDE_G: side_lamp = LAMP_G;
      S_SIDE_Y: side_lamp = LAMP_Y;
      default:  side_lamp = LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Request inputs and lamp/debug outputs of the traffic light controller.
interface traffic_light_ctrl_if;
  logic       side_req;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output side_req, ped_req,
    input  main_light, side_light, walk, phase
  );

  modport slave (
    input  side_req, ped_req,
    output main_light, side_light, walk, phase
  );
endinterface

// File: rtl/tl_tick_gen.sv
// Timing prescaler: free-running modulo-CLK_PER_TICK counter, restarted by clr,
// producing a one-cycle tick once per period.
module tl_tick_gen #(
  parameter int CLK_PER_TICK = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLK_PER_TICK);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);
  localparam logic [CW-1:0] TC   = CW'(CLK_PER_TICK - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr || cnt == LAST) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

  // Tick sits one count before wrap so the timer hits zero on the cycle
  // before the period ends and the phase change lands exactly on N periods.
  assign tick = (cnt == TC);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer: six-phase Moore FSM with tick-based phase
// timer, synchronised request inputs and a pending-service latch.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int CLK_PER_TICK = 1000,
  parameter int GREEN_MIN    = 10,
  parameter int SIDE_GREEN   = 6,
  parameter int YELLOW       = 3,
  parameter int ALL_RED      = 1,
  parameter int TW           = 8
) (
  input  logic clk,
  input  logic rst_n,
  traffic_light_ctrl_if.slave bus
);

  logic            side_req_p0, side_req_p1;
  logic            ped_req_p0,  ped_req_p1;
  logic            req_sync;
  logic            pending;
  logic            tick;
  logic            done;
  logic            state_chg;
  logic [TW-1:0]   timer;
  tl_state_e       state, state_nxt;
  logic [2:0]      main_q, side_q;
  logic            walk_q;

  function automatic logic [TW-1:0] phase_dur(input tl_state_e s);
    case (s)
      S_MAIN_G:           phase_dur = TW'(GREEN_MIN);
      S_MAIN_Y, S_SIDE_Y: phase_dur = TW'(YELLOW);
      S_SIDE_G:           phase_dur = TW'(SIDE_GREEN);
      default:            phase_dur = TW'(ALL_RED);
    endcase
  endfunction

  // Stage p0/p1: two-flop synchronisers on the asynchronous request inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side_req_p0 <= 1'b0;
      side_req_p1 <= 1'b0;
      ped_req_p0  <= 1'b0;
      ped_req_p1  <= 1'b0;
    end else begin
      side_req_p0 <= bus.side_req;
      side_req_p1 <= side_req_p0;
      ped_req_p0  <= bus.ped_req;
      ped_req_p1  <= ped_req_p0;
    end
  end

  assign req_sync = side_req_p1 | ped_req_p1;

  tl_tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_chg),
    .tick (tick)
  );

  assign done = (timer == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_MAIN_G: if (done && pending) state_nxt = S_MAIN_Y;
      S_MAIN_Y: if (done)            state_nxt = S_ALL_R1;
      S_ALL_R1: if (done)            state_nxt = S_SIDE_G;
      S_SIDE_G: if (done)            state_nxt = S_SIDE_Y;
      S_SIDE_Y: if (done)            state_nxt = S_ALL_R2;
      S_ALL_R2: if (done)            state_nxt = S_MAIN_G;
      default:                       state_nxt = S_ALL_R2;
    endcase
  end

  assign state_chg = (state_nxt != state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_ALL_R2;
      timer   <= TW'(ALL_RED);
      pending <= 1'b0;
      main_q  <= LAMP_R;
      side_q  <= LAMP_R;
      walk_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_chg)
        timer <= phase_dur(state_nxt);
      else if (tick && !done)
        timer <= timer - TW'(1);
      // Entering side green consumes the request, even if one is still present.
      if (state_chg && state_nxt == S_SIDE_G)
        pending <= 1'b0;
      else if (req_sync && state != S_SIDE_G)
        pending <= 1'b1;
      main_q <= main_lamp(state_nxt);
      side_q <= side_lamp(state_nxt);
      walk_q <= (state_nxt == S_SIDE_G);
    end
  end

  assign bus.main_light = main_q;
  assign bus.side_light = side_q;
  assign bus.walk       = walk_q;
  assign bus.phase      = state;

endmodule
